// File: rtl/rsc_pkg.sv
// Shared types and constants for the parallel RSC constituent encoder.
package rsc_pkg;

  // Frame-level sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // LTE constituent polynomials, bit i = coefficient of D^i.
  localparam logic [3:0] LTE_G_FB = 4'b1101;  // 1 + D^2 + D^3
  localparam logic [3:0] LTE_G_FF = 4'b1011;  // 1 + D + D^3

  localparam int unsigned FRAME_CNT_W = 16;

  // Integer ceiling division, used to size the tail in beats.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/rsc_step.sv
// Single-bit RSC trellis step. In tail mode the input bit is replaced by the
// feedback sum so the register input a is forced to zero (termination).
module rsc_step
  import rsc_pkg::*;
#(
  parameter int unsigned    MEM  = 3,
  parameter logic [MEM:0]   G_FB = LTE_G_FB,
  parameter logic [MEM:0]   G_FF = LTE_G_FF
) (
  input  logic [MEM-1:0] s_in,
  input  logic           u,
  input  logic           tail_mode,
  output logic [MEM-1:0] s_out,
  output logic           x,
  output logic           z
);

  logic fb;
  logic ff;
  logic u_eff;
  logic a;

  // Coefficient i pairs with register tap s[i-1].
  assign fb    = ^(G_FB[MEM:1] & s_in);
  assign ff    = ^(G_FF[MEM:1] & s_in);
  assign u_eff = tail_mode ? fb : u;
  assign a     = u_eff ^ fb;
  assign x     = u_eff;
  assign z     = (G_FF[0] & a) ^ ff;
  // Shift: s[0] <= a, s[i] <= s[i-1].
  assign s_out = MEM'({s_in, a});

endmodule

// File: rtl/rsc_encoder_par.sv
// Parallel recursive systematic convolutional encoder: LANES bits per beat,
// trellis termination with tail beats, frame-delimited valid/ready.
// Optional: define RSC_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter.
module rsc_encoder_par
  import rsc_pkg::*;
#(
  parameter int unsigned  LANES = 2,
  parameter int unsigned  MEM   = 3,
  parameter logic [MEM:0] G_FB  = LTE_G_FB,
  parameter logic [MEM:0] G_FF  = LTE_G_FF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_bof,
  input  logic                 i_eof,
  input  logic [LANES-1:0]     i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_bof,
  output logic                 o_eof,
  output logic                 o_tail,
  output logic [LANES-1:0]     o_keep,
  output logic [2*LANES-1:0]   o_data,
`ifdef RSC_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
`endif
  output logic                 o_err
);

  localparam int unsigned TAIL_BEATS = ceil_div(MEM, LANES);
  localparam int unsigned TCW        = (TAIL_BEATS > 1) ? $clog2(TAIL_BEATS) : 1;

  state_t               state_q, state_d;
  logic [MEM-1:0]       s_q, s_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic                 valid_d, bof_d, eof_d, tail_d, err_d;
  logic [LANES-1:0]     keep_d;
  logic [2*LANES-1:0]   data_d;

  logic                 out_free;
  logic                 accept;
  logic                 is_tail;
  logic                 tail_last;
  logic [MEM-1:0]       s_chain [0:LANES];
  logic [LANES-1:0]     lane_x;
  logic [LANES-1:0]     lane_z;
  logic [LANES-1:0]     tail_keep;
  logic [2*LANES-1:0]   enc_data;
  logic [2*LANES-1:0]   tail_data;

  assign out_free  = !o_valid || i_ready;
  assign o_ready   = !i_rst && (state_q != ST_TAIL) && out_free;
  assign accept    = i_valid && o_ready;
  assign is_tail   = (state_q == ST_TAIL);
  assign tail_last = (tcnt_q == TCW'(TAIL_BEATS - 1));

  // A frame start always encodes from the all-zero state.
  assign s_chain[0] = (accept && i_bof) ? '0 : s_q;

  // Unrolled trellis chain, lane 0 earliest; shared by data and tail beats.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rsc_step #(
      .MEM  (MEM),
      .G_FB (G_FB),
      .G_FF (G_FF)
    ) u_step (
      .s_in      (s_chain[k]),
      .u         (is_tail ? 1'b0 : i_data[k]),
      .tail_mode (is_tail),
      .s_out     (s_chain[k+1]),
      .x         (lane_x[k]),
      .z         (lane_z[k])
    );
  end

  // Lane packing and tail-lane masking beyond the MEM tail bits.
  always_comb begin
    tail_keep = '0;
    enc_data  = '0;
    tail_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      enc_data[2*k +: 2] = {lane_z[k], lane_x[k]};
      if ((32'(tcnt_q) * LANES + k) < MEM) begin
        tail_keep[k]        = 1'b1;
        tail_data[2*k +: 2] = {lane_z[k], lane_x[k]};
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    tcnt_d  = tcnt_q;
    valid_d = o_valid;
    bof_d   = o_bof;
    eof_d   = o_eof;
    tail_d  = o_tail;
    keep_d  = o_keep;
    data_d  = o_data;
    err_d   = 1'b0;

    if (o_valid && i_ready) begin
      valid_d = 1'b0;
      bof_d   = 1'b0;
      eof_d   = 1'b0;
      tail_d  = 1'b0;
      keep_d  = '0;
      data_d  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_bof) begin
            valid_d = 1'b1;
            bof_d   = 1'b1;
            eof_d   = 1'b0;
            tail_d  = 1'b0;
            keep_d  = '1;
            data_d  = enc_data;
            s_d     = s_chain[LANES];
            tcnt_d  = '0;
            state_d = i_eof ? ST_TAIL : ST_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          valid_d = 1'b1;
          bof_d   = i_bof;
          eof_d   = 1'b0;
          tail_d  = 1'b0;
          keep_d  = '1;
          data_d  = enc_data;
          s_d     = s_chain[LANES];
          err_d   = i_bof;
          if (i_eof) begin
            tcnt_d  = '0;
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (out_free) begin
          valid_d = 1'b1;
          bof_d   = 1'b0;
          eof_d   = tail_last;
          tail_d  = 1'b1;
          keep_d  = tail_keep;
          data_d  = tail_data;
          s_d     = s_chain[LANES];
          tcnt_d  = tcnt_q + 1'b1;
          if (tail_last) begin
            s_d     = '0;
            tcnt_d  = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      tcnt_q  <= '0;
      o_valid <= 1'b0;
      o_bof   <= 1'b0;
      o_eof   <= 1'b0;
      o_tail  <= 1'b0;
      o_keep  <= '0;
      o_data  <= '0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      tcnt_q  <= tcnt_d;
      o_valid <= valid_d;
      o_bof   <= bof_d;
      o_eof   <= eof_d;
      o_tail  <= tail_d;
      o_keep  <= keep_d;
      o_data  <= data_d;
      o_err   <= err_d;
    end
  end

`ifdef RSC_FRAME_CNT_EN
  // Completed-frame counter, bumped on each last-tail-beat handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
    end else if (o_valid && i_ready && o_eof) begin
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rsc_encoder_par.sv
// Self-checking bench for rsc_encoder_par (LTE default build).
// Reference model works on the feedback-sequence form a[n] of the code.
module tb_rsc_encoder_par;

  localparam int unsigned LANES      = 2;
  localparam int unsigned MEM        = 3;
  localparam logic [MEM:0] G_FB      = 4'b1101;
  localparam logic [MEM:0] G_FF      = 4'b1011;
  localparam int unsigned TAIL_BEATS = (MEM + LANES - 1) / LANES;

  typedef struct packed {
    logic [2*LANES-1:0] data;
    logic [LANES-1:0]   keep;
    logic               bof;
    logic               eof;
    logic               tail;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid, i_bof, i_eof, i_ready;
  logic [LANES-1:0]   i_data;
  logic               o_ready, o_valid, o_bof, o_eof, o_tail, o_err;
  logic [LANES-1:0]   o_keep;
  logic [2*LANES-1:0] o_data;
`ifdef RSC_FRAME_CNT_EN
  logic [15:0]        o_frame_cnt;
`endif

  int checks     = 0;
  int failures   = 0;
  int err_cnt    = 0;
  int exp_frames = 0;
  int rdy_mode   = 0;  // 0: always ready, 1: random, 2: held low
  beat_t obs_q[$];
  beat_t exp_q[$];
  bit    a_hist[$];

  always #5 clk = ~clk;

  rsc_encoder_par #(
    .LANES (LANES),
    .MEM   (MEM),
    .G_FB  (G_FB),
    .G_FF  (G_FF)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .i_bof       (i_bof),
    .i_eof       (i_eof),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_bof       (o_bof),
    .o_eof       (o_eof),
    .o_tail      (o_tail),
    .o_keep      (o_keep),
    .o_data      (o_data),
`ifdef RSC_FRAME_CNT_EN
    .o_frame_cnt (o_frame_cnt),
`endif
    .o_err       (o_err)
  );

  // Downstream ready driver, updated 2 time units after each rising edge.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(0, 3) != 0);
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: records handshaken beats and error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) begin
        beat_t b;
        b.data = o_data;
        b.keep = o_keep;
        b.bof  = o_bof;
        b.eof  = o_eof;
        b.tail = o_tail;
        obs_q.push_back(b);
      end
      if (o_err) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit a_at(input int n);
    if (n < 0 || n >= a_hist.size()) return 1'b0;
    return a_hist[n];
  endfunction

  function automatic bit fb_sum(input int n);
    bit r = 1'b0;
    for (int i = 1; i <= int'(MEM); i++) r ^= G_FB[i] & a_at(n - i);
    return r;
  endfunction

  function automatic bit ff_sum(input int n);
    bit r = 1'b0;
    for (int i = 1; i <= int'(MEM); i++) r ^= G_FF[i] & a_at(n - i);
    return r;
  endfunction

  task automatic model_frame(input bit ub[$], input bit with_tail);
    int nb;
    int n;
    beat_t e;
    bit u, a, z, f;
    nb = ub.size() / LANES;
    a_hist.delete();
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int k = 0; k < int'(LANES); k++) begin
        n = b * LANES + k;
        u = ub[n];
        a = u ^ fb_sum(n);
        z = (G_FF[0] & a) ^ ff_sum(n);
        a_hist.push_back(a);
        e.data[2*k]   = u;
        e.data[2*k+1] = z;
        e.keep[k]     = 1'b1;
      end
      e.bof = (b == 0);
      exp_q.push_back(e);
    end
    if (with_tail) begin
      n = nb * LANES;
      for (int t = 0; t < int'(TAIL_BEATS); t++) begin
        e = '0;
        e.tail = 1'b1;
        e.eof  = (t == int'(TAIL_BEATS) - 1);
        for (int k = 0; k < int'(LANES); k++) begin
          if (t * LANES + k < MEM) begin
            f = fb_sum(n);
            z = ff_sum(n);
            a_hist.push_back(1'b0);
            e.data[2*k]   = f;
            e.data[2*k+1] = z;
            e.keep[k]     = 1'b1;
            n++;
          end
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Entered and left at one time unit after a rising edge.
  task automatic send_beat(input bit bof, input bit eof, input logic [LANES-1:0] d);
    bit ok = 1'b0;
    bit acc;
    i_valid = 1'b1;
    i_bof   = bof;
    i_eof   = eof;
    i_data  = d;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    i_bof   = 1'b0;
    i_eof   = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_beat timeout: o_ready=%b required 1 within 500 cycles", o_ready);
    end
  endtask

  task automatic send_frame(input int nb, input bit with_tail, input int gap_max);
    bit ub[$];
    logic [LANES-1:0] d;
    for (int b = 0; b < nb; b++) begin
      d = LANES'($urandom);
      for (int k = 0; k < int'(LANES); k++) ub.push_back(d[k]);
      send_beat(b == 0, with_tail && (b == nb - 1), d);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
    model_frame(ub, with_tail);
    if (with_tail) exp_frames++;
  endtask

  task automatic check_stream(input string name);
    int n;
    for (int c = 0; c < 3000; c++) begin
      if (obs_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s beat_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s beat %0d: got data=%h keep=%b bof=%b eof=%b tail=%b required data=%h keep=%b bof=%b eof=%b tail=%b",
                 name, i, obs_q[i].data, obs_q[i].keep, obs_q[i].bof, obs_q[i].eof, obs_q[i].tail,
                 exp_q[i].data, exp_q[i].keep, exp_q[i].bof, exp_q[i].eof, exp_q[i].tail);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_ready, o_valid, o_bof, o_eof, o_tail, o_err, o_keep, o_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required all zero",
               {o_ready, o_valid, o_bof, o_eof, o_tail, o_err, o_keep, o_data});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b required ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_single_beat();
    beat_t e;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_valid: got %b required 0", o_valid);
    end
    send_beat(1'b1, 1'b1, 2'b01);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 4'b1011 || o_keep !== 2'b11 || o_bof !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: got valid=%b data=%b keep=%b bof=%b required 1 1011 11 1",
               o_valid, o_data, o_keep, o_bof);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_tail_ready: got %b required 0", o_ready);
    end
    e = '0; e.data = 4'b1011; e.keep = 2'b11; e.bof = 1'b1;             exp_q.push_back(e);
    e = '0; e.data = 4'b1101; e.keep = 2'b11; e.tail = 1'b1;            exp_q.push_back(e);
    e = '0; e.data = 4'b0000; e.keep = 2'b01; e.tail = 1'b1; e.eof = 1'b1; exp_q.push_back(e);
    exp_frames++;
    check_stream("single");
  endtask

  task automatic test_errors();
    int e0;
    bit ub1[$];
    bit ub2[$];
    logic [LANES-1:0] d;
    // Beat without bof while idle is dropped.
    e0 = err_cnt;
    send_beat(1'b0, 1'b0, 2'b11);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (err_cnt - e0 != 1 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL idle_nobof: got err_pulses=%0d beats=%0d required 1 and 0", err_cnt - e0, obs_q.size());
    end
    // bof inside an open frame restarts from zero state; old frame gets no tail.
    e0 = err_cnt;
    for (int b = 0; b < 3; b++) begin
      d = LANES'($urandom);
      for (int k = 0; k < int'(LANES); k++) ub1.push_back(d[k]);
      send_beat(b == 0, 1'b0, d);
    end
    for (int b = 0; b < 2; b++) begin
      d = LANES'($urandom);
      for (int k = 0; k < int'(LANES); k++) ub2.push_back(d[k]);
      send_beat(b == 0, b == 1, d);
    end
    model_frame(ub1, 1'b0);
    model_frame(ub2, 1'b1);
    exp_frames++;
    check_stream("bof_in_data");
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL bof_in_data_err: got %0d pulses required 1", err_cnt - e0);
    end
  endtask

  task automatic test_backpressure();
    bit ub[$];
    logic [LANES-1:0] d;
    rdy_mode = 0;
    for (int i = 0; i < 56 * int'(LANES); i++) ub.push_back(1'($urandom));
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < int'(LANES); k++) d[k] = ub[b*LANES+k];
      send_beat(b == 0, 1'b0, d);
    end
    rdy_mode = 2;
    fork
      begin
        logic [2*LANES-1:0] snap;
        @(negedge clk);
        snap = o_data;
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          checks++;
          if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== snap) begin
            failures++;
            $display("FAIL hold cycle %0d: got valid=%b ready=%b data=%h required 1 0 %h",
                     c, o_valid, o_ready, o_data, snap);
          end
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
      end
      begin
        for (int b = 20; b < 56; b++) begin
          for (int k = 0; k < int'(LANES); k++) d[k] = ub[b*LANES+k];
          send_beat(1'b0, b == 55, d);
        end
      end
    join
    model_frame(ub, 1'b1);
    exp_frames++;
    check_stream("backpressure");
    rdy_mode = 0;
  endtask

  task automatic test_reset_in_tail();
    rdy_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_beat(1'b1, 1'b1, LANES'($urandom));
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL tail_stall: got ready=%b valid=%b required 0 1", o_ready, o_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_ready, o_valid, o_bof, o_eof, o_tail, o_err, o_keep, o_data} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %b required all zero",
               {o_ready, o_valid, o_bof, o_eof, o_tail, o_err, o_keep, o_data});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_eof, o_tail, o_keep, o_data} !== '0) begin
      failures++;
      $display("FAIL reset_edge: got %b required all zero", {o_valid, o_eof, o_tail, o_keep, o_data});
    end
    rst = 1'b0;
    exp_frames = 0;
    rdy_mode = 0;
    obs_q.delete();
    exp_q.delete();
    send_frame(3, 1'b1, 1);
    check_stream("after_reset");
`ifdef RSC_FRAME_CNT_EN
    checks++;
    if (o_frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL frame_cnt_after_reset: got %0d required %0d", o_frame_cnt, exp_frames);
    end
`endif
  endtask

  task automatic test_random_frames();
    rdy_mode = 1;
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 10), 1'b1, 2);
    check_stream("random");
    rdy_mode = 0;
`ifdef RSC_FRAME_CNT_EN
    checks++;
    if (o_frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL frame_cnt: got %0d required %0d", o_frame_cnt, exp_frames);
    end
`endif
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_bof   = 1'b0;
    i_eof   = 1'b0;
    i_data  = '0;
    test_reset();
    test_single_beat();
    test_errors();
    test_backpressure();
    test_reset_in_tail();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsc_encoder_par.md
Name: rsc_encoder_par

Overview:
- Parametrised recursive systematic convolutional (RSC) constituent encoder; successor to the fixed 2-bit/3-memory constituent inside the turbo encoder top.
- Encodes LANES bits per accepted beat, with generic memory depth and generator polynomials.
- Adds trellis termination (tail emission) and a per-lane keep mask.
- Sits between the frame source (Caravel LA / interleaver) and the output packer; frame-delimited valid/ready on both sides.

Parameters:
- LANES, 2: information bits per beat.
- MEM, 3: encoder memory (constraint length MEM+1).
- G_FB, 4'b1101: feedback polynomial, bit i = coefficient of D^i (LTE g0 = 1+D^2+D^3); width MEM+1.
- G_FF, 4'b1011: feed-forward polynomial, same encoding (LTE g1 = 1+D+D^3); width MEM+1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_bof  in  1  first beat of frame.
- i_eof  in  1  last beat of frame.
- i_data  in  LANES  info bits; bit 0 is earliest in time.
- o_ready  out  1  block can accept an input beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_bof  out  1  first output beat of frame.
- o_eof  out  1  last output beat of frame (last tail beat).
- o_tail  out  1  beat carries tail bits.
- o_keep  out  LANES  valid-lane mask.
- o_data  out  2*LANES  lane k at [2k+1:2k] = {parity z_k, systematic x_k}.
- o_err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset: all outputs 0; state register s[MEM-1:0] = 0; FSM = IDLE.
- Bit recurrence, per bit u in lane order:
  - a = u ^ XOR_{i=1..MEM}(G_FB[i] & s[i-1])
  - z = (G_FF[0] & a) ^ XOR_{i=1..MEM}(G_FF[i] & s[i-1])
  - x = u; then shift s[0] <= a, s[i] <= s[i-1].
- LANES bits are unrolled combinationally within one cycle.
- Output register: single stage; latency is 1 cycle from accept to o_valid.
  - o_ready = (FSM != TAIL) && (!o_valid || i_ready).
  - Registered outputs hold stable while o_valid && !i_ready.
- Accept = i_valid && o_ready.
- FSM:
  - IDLE: accept with i_bof → encode, o_bof=1; go to DATA, or to TAIL if i_eof is set on the same beat.
  - DATA: accept → encode; i_eof → TAIL.
  - TAIL: per tail bit, u = XOR_{i=1..MEM}(G_FB[i] & s[i-1]), forcing a = 0.
    - Emit ceil(MEM/LANES) beats with o_tail=1; unused lanes have o_keep bit 0 and data 0.
    - o_eof=1 on the last tail beat; advance only when the output register is free.
    - After the last tail beat, s is all zero → IDLE.
- Errors:
  - Accept in IDLE without i_bof → beat dropped, o_err pulse.
  - i_bof in DATA → o_err pulse; s cleared before encoding; beat starts a new frame with o_bof=1; previous frame gets no tail.
- Async reset mid-frame aborts immediately; no tail is emitted.

Optional Feature:
- RSC_FRAME_CNT_EN defined: adds port o_frame_cnt (out, 16), incremented on each o_eof handshake, wraps 0xFFFF→0, reset 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package rsc_pkg:
  - FSM state enum (IDLE, DATA, TAIL).
  - LTE polynomial constants.
  - function ceil_div for tail beat count.
- Sub-module rsc_step: combinational single-bit step (s_in, u, tail_mode → s_out, x, z).
  - Instantiated LANES times in a chain; shared by data and tail paths.

Test Plan:
- LTE default, reset, one beat {bof=1, data=2'b01} → o_data=4'b1011, o_keep=2'b11, o_bof=1, 1-cycle latency.
- Same frame with eof on that beat → tail beats o_data=4'b1101 keep=2'b11, then o_data=4'b0000 keep=2'b01 o_eof=1 o_tail=1; state returns to 0.
- Hold i_ready=0 for 5 cycles mid-frame → o_data stable, o_ready=0, no beats lost; compare full 56-beat frame to reference model.
- Beat without bof in IDLE → o_err pulse, no o_valid; bof in DATA → o_err, new o_bof, no tail for aborted frame.
- Assert i_rst during TAIL → all outputs 0 next edge, subsequent bof frame encodes from state 0.
- LANES=4, MEM=3 and LANES=1 builds, random frames → bit-exact vs reference model, tail lengths 1 and 3 beats; with RSC_FRAME_CNT_EN, o_frame_cnt equals frames completed.
